// File: rtl/rand_gen_pkg.sv
// Shared constants and helpers for the multi-channel range/Bernoulli generator.
package rand_gen_pkg;

  localparam logic [31:0] LFSR_MASK   = 32'h8020_0003;
  localparam logic [31:0] SEED_SPREAD = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r);
    return (r >> 1) ^ (r[0] ? LFSR_MASK : 32'h0);
  endfunction

  // All-zero would lock the LFSR, so it is replaced by all-ones.
  function automatic logic [31:0] chan_seed(input logic [31:0] s, input int i);
    logic [31:0] v;
    v = s ^ (SEED_SPREAD * 32'(i));
    return (v == 32'h0) ? 32'hFFFF_FFFF : v;
  endfunction

endpackage

// File: rtl/lfsr32_scale.sv
// One channel: 32-bit Galois LFSR, stage-1 sample register and the
// range/Bernoulli scaling into the output register.
module lfsr32_scale
  import rand_gen_pkg::*;
#(
  parameter int          RSIZE = 10,
  parameter int          PX    = 67,
  parameter logic [31:0] SEED  = 32'h0000_0001,
  parameter int          IDX   = 0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_seed_load,
  input  logic [31:0]      i_seed,
  input  logic             i_accept,
  input  logic             i_s1_adv,
  input  logic [RSIZE-1:0] i_lo,
  input  logic [RSIZE-1:0] i_hi,
  input  logic             i_err,
  output logic [RSIZE-1:0] o_range,
  output logic             o_bern
);

  localparam int PW = RSIZE + 17;

  logic [31:0]      r_lfsr;
  logic [31:0]      r_s1;
  logic [RSIZE-1:0] r_range;
  logic             r_bern;

  logic [31:0]      w_next;
  logic [RSIZE:0]   w_span;
  logic [PW-1:0]    w_prod;
  logic [22:0]      w_pct;
  logic [RSIZE-1:0] w_range;
  logic             w_bern;

  always_comb begin
    w_next  = lfsr_step(r_lfsr);
    w_span  = {1'b0, i_hi} - {1'b0, i_lo} + {{RSIZE{1'b0}}, 1'b1};
    w_prod  = PW'(r_s1[15:0]) * PW'(w_span);
    w_range = i_err ? i_lo : RSIZE'(PW'(i_lo) + (w_prod >> 16));
    w_pct   = 23'(r_s1[31:16]) * 23'd100;
    w_bern  = (w_pct >> 16) < 23'(PX);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= chan_seed(SEED, IDX);
      r_s1    <= '0;
      r_range <= '0;
      r_bern  <= 1'b0;
    end else begin
      if (i_seed_load) begin
        r_lfsr <= chan_seed(i_seed, IDX);
      end else if (i_accept) begin
        r_lfsr <= w_next;
        r_s1   <= w_next;
      end
      if (i_s1_adv) begin
        r_range <= w_range;
        r_bern  <= w_bern;
      end
    end
  end

  assign o_range = r_range;
  assign o_bern  = r_bern;

endmodule

// File: rtl/rand_range_gen.sv
// Multi-channel pseudo-random range/Bernoulli source: request handshake,
// 2-stage valid pipeline with backpressure, runtime reseed and output packing.
module rand_range_gen
  import rand_gen_pkg::*;
#(
  parameter int          CH    = 4,
  parameter int          RSIZE = 10,
  parameter int          PX    = 67,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                seed_load,
  input  logic [31:0]         seed,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [RSIZE-1:0]    lo,
  input  logic [RSIZE-1:0]    hi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*RSIZE-1:0] rd_range,
  output logic [CH-1:0]       bern_b,
  output logic                cfg_err
);

  logic             r_s1_valid;
  logic [RSIZE-1:0] r_s1_lo;
  logic [RSIZE-1:0] r_s1_hi;
  logic             r_s1_err;
  logic             r_out_valid;
  logic             r_cfg_err;

  logic w_out_load;
  logic w_s1_adv;
  logic w_accept;

  always_comb begin
    w_out_load = !r_out_valid || out_ready;
    w_s1_adv   = r_s1_valid && w_out_load;
    req_ready  = !seed_load && (!r_s1_valid || w_s1_adv);
    w_accept   = req_valid && req_ready;
  end

  // Reseed flushes both pipeline stages; it wins over any advance.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_lo     <= '0;
      r_s1_hi     <= '0;
      r_s1_err    <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else if (seed_load) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_lo    <= lo;
        r_s1_hi    <= hi;
        r_s1_err   <= (hi < lo);
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_out_load) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s1_adv) begin
        r_cfg_err <= r_s1_err;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    lfsr32_scale #(
      .RSIZE(RSIZE),
      .PX   (PX),
      .SEED (SEED),
      .IDX  (g)
    ) u_ch (
      .clock      (clock),
      .rst_n      (rst_n),
      .i_seed_load(seed_load),
      .i_seed     (seed),
      .i_accept   (w_accept),
      .i_s1_adv   (w_s1_adv),
      .i_lo       (r_s1_lo),
      .i_hi       (r_s1_hi),
      .i_err      (r_s1_err),
      .o_range    (rd_range[g*RSIZE +: RSIZE]),
      .o_bern     (bern_b[g])
    );
  end

  assign out_valid = r_out_valid;
  assign cfg_err   = r_cfg_err;

endmodule
